// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU feeding a 2-entry in-order valid/ready output queue
module ex_alu_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic [7:0]       illegal_count
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
    logic [4:0]       rd;
    logic             reg_write;
  } entry_t;
  entry_t           r_q0, r_q1, w_new;
  logic [1:0]       r_count;
  logic             r_live;
  logic [7:0]       r_ill_cnt;
  logic [WIDTH-1:0] w_sum, w_diff, w_res;
  logic             w_ovf, w_ill, w_push, w_pop;
  assign w_sum  = src_a + src_b;
  assign w_diff = src_a - src_b;
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (alu_ctl)
      4'b0000: w_res = src_a & src_b;
      4'b0001: w_res = src_a | src_b;
      4'b0010: begin
        w_res = w_sum;
        w_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'b0110: begin
        w_res = w_diff;
        w_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b1100: w_res = ~(src_a | src_b);
      default: w_ill = 1'b1;
    endcase
  end
  assign w_new = '{result: w_res, zero: (w_res == '0), ovf: w_ovf, illegal: w_ill, rd: in_rd,
                   reg_write: in_reg_write && !w_ovf && !w_ill && (in_rd != 5'd0)};
  // in_ready comes only from registered state; r_live holds it low until the first edge after reset
  assign in_ready  = r_live && (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0      <= '0;
      r_q1      <= '0;
      r_count   <= 2'd0;
      r_live    <= 1'b0;
      r_ill_cnt <= 8'd0;
    end else begin
      r_live <= 1'b1;
      if (w_push && w_ill && r_ill_cnt != 8'hFF) r_ill_cnt <= r_ill_cnt + 8'd1;
      if (flush) r_count <= 2'd0;
      else begin
        if (w_pop) r_q0 <= r_q1;
        // slot for the new entry is the occupancy left after any pop
        if (w_push && (r_count - {1'b0, w_pop}) == 2'd0) r_q0 <= w_new;
        else if (w_push) r_q1 <= w_new;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end
  assign out_result    = out_valid ? r_q0.result : '0;
  assign out_zero      = out_valid && r_q0.zero;
  assign out_ovf       = out_valid && r_q0.ovf;
  assign out_illegal   = out_valid && r_q0.illegal;
  assign out_rd        = out_valid ? r_q0.rd : 5'd0;
  assign out_reg_write = out_valid && r_q0.reg_write;
  assign illegal_count = r_ill_cnt;
endmodule
